// File: rtl/mic1_loader_pkg.sv
// Shared opcodes, reply bytes, reply lengths and FSM state encoding for the
// MIC-1 UART program loader.
package mic1_loader_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam logic [2:0] LEN_ACK  = 3'd1;
  localparam logic [2:0] LEN_READ = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_READ,
    S_RWAIT,
    S_TX,
    S_TXWAIT
  } state_t;

endpackage

// File: rtl/loader_byte_sender.sv
// Sends up to four queued bytes MSB-first over the uart_tx start/busy handshake
// and pulses done once the last byte has left the transmitter.
module loader_byte_sender
  import mic1_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  state_t      state;
  logic [31:0] queue;
  logic [2:0]  remaining;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      queue     <= '0;
      remaining <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (load) begin
          tx_data   <= load_data[31:24];
          queue     <= {load_data[23:0], 8'h00};
          remaining <= load_len - 3'd1;
          tx_start  <= 1'b1;
          state     <= S_TX;
        end
        // tx_start stays up until the transmitter acknowledges by going busy
        S_TX: if (tx_busy) begin
          tx_start <= 1'b0;
          state    <= S_TXWAIT;
        end
        S_TXWAIT: if (!tx_busy) begin
          if (remaining == 3'd0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            tx_data   <= queue[31:24];
            queue     <= {queue[23:0], 8'h00};
            remaining <= remaining - 3'd1;
            tx_start  <= 1'b1;
            state     <= S_TX;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mic1_uart_loader.sv
// Host-side UART frame parser driving the MIC-1 main-memory external port and
// the CPU run line; replies go out through loader_byte_sender.
module mic1_uart_loader
  import mic1_loader_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 1_000_000,
  parameter int   READ_LATENCY   = 1,
  parameter logic RUN_AT_RESET   = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RWAIT_LAST   = 8'(READ_LATENCY - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic        is_write;
  logic        reject;
  logic [23:0] addr_sh;
  logic [23:0] data_sh;
  logic [31:0] addr_hold;
  logic [31:0] timer;
  logic [7:0]  rwait_cnt;
  logic        send_load;
  logic [31:0] send_data;
  logic [2:0]  send_len;
  logic        send_done;

  assign busy = (state != S_IDLE);

  // reject captures cpu_run at the command byte so a W/R started while running is consumed then NAKed
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      reject    <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      addr_hold <= '0;
      timer     <= '0;
      rwait_cnt <= '0;
      send_load <= 1'b0;
      send_data <= '0;
      send_len  <= '0;
      cpu_run   <= RUN_AT_RESET;
      mem_sel   <= !RUN_AT_RESET;
      frame_err <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
    end else begin
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      send_load <= 1'b0;
      case (state)
        S_IDLE: if (rx_valid) begin
          cnt       <= '0;
          timer     <= '0;
          reject    <= cpu_run;
          send_len  <= LEN_ACK;
          send_data <= {ACK, 24'h0};
          case (rx_data)
            CMD_W, CMD_R: begin
              is_write <= (rx_data == CMD_W);
              state    <= S_ADDR;
            end
            CMD_G: begin
              cpu_run   <= 1'b1;
              mem_sel   <= 1'b0;
              send_load <= 1'b1;
              state     <= S_TX;
            end
            CMD_H: begin
              cpu_run   <= 1'b0;
              mem_sel   <= 1'b1;
              send_load <= 1'b1;
              state     <= S_TX;
            end
            CMD_C: begin
              frame_err <= 1'b0;
              send_load <= 1'b1;
              state     <= S_TX;
            end
            default: begin
              frame_err <= 1'b1;
              send_data <= {NAK, 24'h0};
              send_load <= 1'b1;
              state     <= S_TX;
            end
          endcase
        end
        S_ADDR: if (rx_valid) begin
          timer   <= '0;
          cnt     <= cnt + 2'd1;
          addr_sh <= {addr_sh[15:0], rx_data};
          if (cnt == 2'd3) begin
            addr_hold <= {addr_sh, rx_data};
            if (is_write) begin
              state <= S_DATA;
            end else if (reject) begin
              frame_err <= 1'b1;
              send_data <= {NAK, 24'h0};
              send_load <= 1'b1;
              state     <= S_TX;
            end else begin
              mem_addr <= {addr_sh, rx_data};
              mem_ren  <= 1'b1;
              state    <= S_READ;
            end
          end
        end else if (timer == TIMEOUT_LAST) begin
          frame_err <= 1'b1;
          state     <= S_IDLE;
        end else begin
          timer <= timer + 32'd1;
        end
        S_DATA: if (rx_valid) begin
          timer   <= '0;
          cnt     <= cnt + 2'd1;
          data_sh <= {data_sh[15:0], rx_data};
          if (cnt == 2'd3) begin
            if (reject) begin
              frame_err <= 1'b1;
              send_data <= {NAK, 24'h0};
              send_load <= 1'b1;
              state     <= S_TX;
            end else begin
              mem_addr  <= addr_hold;
              mem_wdata <= {data_sh, rx_data};
              mem_wen   <= 1'b1;
              state     <= S_WRITE;
            end
          end
        end else if (timer == TIMEOUT_LAST) begin
          frame_err <= 1'b1;
          state     <= S_IDLE;
        end else begin
          timer <= timer + 32'd1;
        end
        S_WRITE: begin
          send_data <= {ACK, 24'h0};
          send_len  <= LEN_ACK;
          send_load <= 1'b1;
          state     <= S_TX;
        end
        S_READ: begin
          rwait_cnt <= '0;
          state     <= S_RWAIT;
        end
        S_RWAIT: if (rwait_cnt == RWAIT_LAST) begin
          send_data <= mem_rdata;
          send_len  <= LEN_READ;
          send_load <= 1'b1;
          state     <= S_TX;
        end else begin
          rwait_cnt <= rwait_cnt + 8'd1;
        end
        S_TX: if (send_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  loader_byte_sender u_sender (
    .clk       (clk),
    .resetn    (resetn),
    .load      (send_load),
    .load_data (send_data),
    .load_len  (send_len),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .done      (send_done)
  );

endmodule

// File: tb/tb_mic1_uart_loader.sv
// Randomized self-checking bench for mic1_uart_loader: frames are scored against a
// host-level model of the loader protocol, with UART and memory stubs around the DUT.
module tb_mic1_uart_loader;
  import mic1_loader_pkg::*;

  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        mem_sel;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_run, busy, frame_err;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  // Reference model state (host view of the loader)
  logic        ref_run = 1'b0;
  logic        ref_err = 1'b0;
  logic [31:0] ref_mem [logic [31:0]];

  // Stub/monitor state
  logic [31:0] stub_mem [logic [31:0]];
  logic [7:0]  got_tx[$];
  int          busy_left = 0;
  int          wen_count = 0, ren_count = 0, strobe_bad = 0;
  int          wen_cycle = 0, ren_cycle = 0, rx_cycle = 0;
  logic [31:0] seen_waddr = 0, seen_wdata = 0, seen_raddr = 0;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_addr = 0;

  mic1_uart_loader #(.TIMEOUT_CYCLES(TIMEOUT), .READ_LATENCY(1), .RUN_AT_RESET(1'b0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory with one clock of read latency (garbage otherwise) and a uart_tx stand-in
  initial forever begin
    @(negedge clk);
    if (rd_pending) mem_rdata = stub_mem.exists(rd_addr) ? stub_mem[rd_addr] : 32'h0;
    else mem_rdata = $urandom;
    rd_pending = mem_ren;
    rd_addr = mem_addr;
    if (mem_wen) begin
      wen_count++;
      wen_cycle = cycle;
      seen_waddr = mem_addr;
      seen_wdata = mem_wdata;
      stub_mem[mem_addr] = mem_wdata;
    end
    if (mem_ren) begin
      ren_count++;
      ren_cycle = cycle;
      seen_raddr = mem_addr;
    end
    if ((mem_wen || mem_ren) && (cpu_run || (mem_wen && mem_ren))) strobe_bad++;
    if (tx_busy) begin
      if (busy_left == 0) tx_busy = 1'b0;
      else busy_left--;
    end else if (tx_start) begin
      got_tx.push_back(tx_data);
      tx_busy = 1'b1;
      busy_left = $urandom_range(1, 6);
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    rx_cycle = cycle;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic waitReply(input int n);
    int i = 0;
    while (i < 3000 && !(got_tx.size() >= n && !busy && !tx_busy)) begin
      @(negedge clk);
      i++;
    end
    checkOutput("reply_in_time", 32'(i < 3000), 32'd1);
  endtask

  // Sends one frame (optionally with a long pause after the third byte) and scores it
  task automatic runFrame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input int pause);
    logic [7:0]  frame[$];
    logic [7:0]  exp_reply[$];
    int          exp_wen = 0;
    int          exp_ren = 0;
    logic [31:0] word;
    frame.push_back(cmd);
    if (cmd == CMD_W || cmd == CMD_R) for (int i = 3; i >= 0; i--) frame.push_back(addr[8*i +: 8]);
    if (cmd == CMD_W) for (int i = 3; i >= 0; i--) frame.push_back(data[8*i +: 8]);
    case (cmd)
      CMD_W: if (ref_run) begin
        ref_err = 1'b1;
        exp_reply.push_back(NAK);
      end else begin
        ref_mem[addr] = data;
        exp_wen = 1;
        exp_reply.push_back(ACK);
      end
      CMD_R: if (ref_run) begin
        ref_err = 1'b1;
        exp_reply.push_back(NAK);
      end else begin
        word = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        exp_ren = 1;
        for (int i = 3; i >= 0; i--) exp_reply.push_back(word[8*i +: 8]);
      end
      CMD_G: begin ref_run = 1'b1; exp_reply.push_back(ACK); end
      CMD_H: begin ref_run = 1'b0; exp_reply.push_back(ACK); end
      CMD_C: begin ref_err = 1'b0; exp_reply.push_back(ACK); end
      default: begin ref_err = 1'b1; exp_reply.push_back(NAK); end
    endcase
    got_tx.delete();
    wen_count = 0;
    ren_count = 0;
    foreach (frame[i]) begin
      applyStimulus(frame[i]);
      if (i == 2) repeat (pause) @(negedge clk);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    waitReply(exp_reply.size());
    checkOutput("reply_len", got_tx.size(), exp_reply.size());
    foreach (exp_reply[i]) if (i < got_tx.size()) checkOutput("reply_byte", {24'h0, got_tx[i]}, {24'h0, exp_reply[i]});
    checkOutput("wen_count", wen_count, exp_wen);
    checkOutput("ren_count", ren_count, exp_ren);
    if (exp_wen == 1) begin
      checkOutput("waddr", seen_waddr, addr);
      checkOutput("wdata", seen_wdata, data);
      checkOutput("wen_latency", wen_cycle - rx_cycle, 32'd1);
    end
    if (exp_ren == 1) begin
      checkOutput("raddr", seen_raddr, addr);
      checkOutput("ren_latency", ren_cycle - rx_cycle, 32'd1);
    end
    checkOutput("cpu_run", {31'h0, cpu_run}, {31'h0, ref_run});
    checkOutput("mem_sel", {31'h0, mem_sel}, {31'h0, !ref_run});
    checkOutput("frame_err", {31'h0, frame_err}, {31'h0, ref_err});
    checkOutput("busy_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic [7:0] bad_cmds [4];
    bad_cmds[0] = 8'h5A; bad_cmds[1] = 8'h00; bad_cmds[2] = 8'hFF; bad_cmds[3] = 8'h77;

    repeat (4) @(negedge clk);
    checkOutput("rst_cpu_run", {31'h0, cpu_run}, 32'h0);
    checkOutput("rst_mem_sel", {31'h0, mem_sel}, 32'h1);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_frame_err", {31'h0, frame_err}, 32'h0);
    checkOutput("rst_tx_start", {31'h0, tx_start}, 32'h0);
    checkOutput("rst_strobes", {30'h0, mem_wen, mem_ren}, 32'h0);
    checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    runFrame(CMD_H, 0, 0, 0);
    runFrame(CMD_W, 32'h10, 32'hDEADBEEF, 0);
    runFrame(CMD_R, 32'h10, 0, 0);
    runFrame(8'h5A, 0, 0, 0);
    runFrame(CMD_C, 0, 0, 0);

    // A partial frame left idle past the timeout is dropped silently
    got_tx.delete();
    wen_count = 0;
    applyStimulus(CMD_W);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    repeat (TIMEOUT + 10) @(negedge clk);
    ref_err = 1'b1;
    checkOutput("timeout_err", {31'h0, frame_err}, 32'h1);
    checkOutput("timeout_idle", {31'h0, busy}, 32'h0);
    checkOutput("timeout_nowen", wen_count, 32'h0);
    checkOutput("timeout_noreply", got_tx.size(), 32'h0);
    runFrame(CMD_G, 0, 0, 0);
    runFrame(CMD_W, 32'h20, 32'h12345678, 0);
    runFrame(CMD_R, 32'h10, 0, 0);
    runFrame(CMD_H, 0, 0, 0);
    runFrame(CMD_C, 0, 0, 0);
    // A pause just short of the timeout must not drop the frame
    runFrame(CMD_W, 32'h30, 32'hCAFEF00D, TIMEOUT - 20);
    runFrame(CMD_R, 32'h30, 0, TIMEOUT - 20);

    for (int n = 0; n < 40; n++) begin
      int          pick;
      logic [7:0]  c;
      logic [31:0] a;
      pick = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 7)) | ((pick % 2 == 0) ? 32'hA500_0000 : 32'h0);
      case (pick)
        0, 1, 2: c = CMD_W;
        3, 4, 5: c = CMD_R;
        6: c = CMD_G;
        7: c = CMD_H;
        8: c = CMD_C;
        default: c = bad_cmds[$urandom_range(0, 3)];
      endcase
      runFrame(c, a, $urandom, 0);
    end

    // Reset in the middle of a read reply aborts it at once
    runFrame(CMD_H, 0, 0, 0);
    runFrame(CMD_W, 32'h44, 32'h0BADC0DE, 0);
    got_tx.delete();
    applyStimulus(CMD_R);
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h44);
    for (int i = 0; i < 500 && got_tx.size() == 0; i++) @(negedge clk);
    checkOutput("reply_started", 32'(got_tx.size() != 0), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("midtx_tx_start", {31'h0, tx_start}, 32'h0);
    checkOutput("midtx_busy", {31'h0, busy}, 32'h0);
    checkOutput("midtx_cpu_run", {31'h0, cpu_run}, 32'h0);
    resetn = 1'b1;
    ref_run = 1'b0;
    ref_err = 1'b0;
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("post_reset_quiet", {31'h0, tx_start}, 32'h0);
    runFrame(CMD_R, 32'h44, 0, 0);

    checkOutput("strobe_rules", strobe_bad, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
